calc_datapath: RTL and testbench

CALC_DATAPATH -- requirements
Module: calc_datapath

---
 rtl/calc_datapath.sv | 171 +++++++++++++++++
 tb/tb_calc_datapath.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/calc_datapath.sv
// Operand/opcode registers and arithmetic unit for a four-function calculator.
// ADD/SUB finish at exec_start; MUL/DIV iterate one bit per clock for ITER clocks.
module calc_datapath #(
  parameter int ITER = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        state,
  input  logic [ITER-1:0]   sw,
  output logic [ITER-1:0]   operand_a,
  output logic [ITER-1:0]   operand_b,
  output logic [2*ITER-1:0] result,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_A  = 3'd1,
    ST_LOAD_B  = 3'd2,
    ST_LOAD_OP = 3'd3,
    ST_EXEC    = 3'd4,
    ST_SHOW    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  state_e              w_state;
  state_e              r_prev;
  op_e                 r_op;
  logic [ITER-1:0]     r_a;
  logic [ITER-1:0]     r_b;
  logic [2*ITER-1:0]   r_result;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [CW-1:0]       r_cnt;
  // r_hi/r_lo: partial product/multiplier for MUL, remainder/quotient for DIV.
  logic [ITER-1:0]     r_hi;
  logic [ITER-1:0]     r_lo;

  logic                w_exec_start;
  logic                w_load_a_entry;
  logic                w_abort;
  logic                w_last;
  logic [ITER:0]       w_mul_sum;
  logic [ITER:0]       w_div_shift;
  logic [ITER-1:0]     w_div_diff;
  logic                w_div_ge;
  logic [ITER-1:0]     w_step_hi;
  logic [ITER-1:0]     w_step_lo;

  // Codes 110/111 behave exactly like IDLE.
  always_comb begin
    w_state = (state > 3'd5) ? ST_IDLE : state_e'(state);
  end

  assign w_exec_start   = (w_state == ST_EXEC) && (r_prev != ST_EXEC);
  assign w_load_a_entry = (w_state == ST_LOAD_A) && (r_prev != ST_LOAD_A);
  assign w_abort        = r_busy && (w_state != ST_EXEC);
  assign w_last         = (r_cnt == CW'(ITER - 1));

  always_comb begin
    w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : {(ITER+1){1'b0}});
    w_div_shift = {r_hi, r_lo[ITER-1]};
    w_div_ge    = (w_div_shift >= {1'b0, r_b});
    w_div_diff  = w_div_shift[ITER-1:0] - r_b;
    if (r_op == OP_MUL) begin
      w_step_hi = w_mul_sum[ITER:1];
      w_step_lo = {w_mul_sum[0], r_lo[ITER-1:1]};
    end else begin
      w_step_hi = w_div_ge ? w_div_diff : w_div_shift[ITER-1:0];
      w_step_lo = {r_lo[ITER-2:0], w_div_ge};
    end
  end

  // Loads are only possible in load states, so operands cannot move during EXEC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= OP_ADD;
      r_prev <= ST_IDLE;
    end else begin
      r_prev <= w_state;
      case (w_state)
        ST_LOAD_A:  r_a  <= sw;
        ST_LOAD_B:  r_b  <= sw;
        ST_LOAD_OP: r_op <= op_e'(sw[1:0]);
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_abort) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else if (w_exec_start) begin
        r_cnt <= '0;
        case (r_op)
          OP_ADD: begin
            r_result <= {{(ITER-1){1'b0}}, ({1'b0, r_a} + {1'b0, r_b})};
            r_done   <= 1'b1;
          end
          OP_SUB: begin
            r_result <= {{ITER{1'b0}}, r_a} - {{ITER{1'b0}}, r_b};
            r_done   <= 1'b1;
          end
          OP_MUL: begin
            r_busy <= 1'b1;
            r_hi   <= '0;
            r_lo   <= r_b;
          end
          OP_DIV: begin
            if (r_b == '0) begin
              r_err    <= 1'b1;
              r_result <= '1;
              r_done   <= 1'b1;
            end else begin
              r_busy <= 1'b1;
              r_hi   <= '0;
              r_lo   <= r_a;
            end
          end
        endcase
      end else if (r_busy) begin
        r_hi <= w_step_hi;
        r_lo <= w_step_lo;
        if (w_last) begin
          r_busy   <= 1'b0;
          r_cnt    <= '0;
          r_result <= {w_step_hi, w_step_lo};
          r_done   <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
      if (w_load_a_entry) begin
        r_result <= '0;
        r_err    <= 1'b0;
      end
    end
  end

  assign operand_a = r_a;
  assign operand_b = r_b;
  assign result    = r_result;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_calc_datapath.sv
// Self-checking bench for calc_datapath: directed vector table, random ops
// against an arithmetic reference model, plus abort and async-reset sequences.
module tb_calc_datapath;

  localparam int ITER = 4;
  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD_A = 3'd1, S_LOAD_B = 3'd2,
                         S_LOAD_OP = 3'd3, S_EXEC = 3'd4, S_SHOW = 3'd5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] state = S_IDLE;
  logic [3:0] sw = 4'd0;
  logic [3:0] operand_a, operand_b;
  logic [7:0] result;
  logic       busy, done, err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [7:0] exp_res;
    logic       exp_err;
    int         exp_busy;
  } vec_t;

  vec_t vecs[7];

  calc_datapath #(.ITER(ITER)) dut (
    .clk(clk), .reset(reset), .state(state), .sw(sw),
    .operand_a(operand_a), .operand_b(operand_b), .result(result),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_res(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] op);
    int ia = int'(a);
    int ib = int'(b);
    case (op)
      2'd0: return 8'(ia + ib);
      2'd1: return 8'(ia - ib);
      2'd2: return 8'(ia * ib);
      default: return (ib == 0) ? 8'hFF : 8'((ia % ib) * 16 + ia / ib);
    endcase
  endfunction

  function automatic int model_busy(input logic [3:0] b, input logic [1:0] op);
    if (op == 2'd2) return ITER;
    if (op == 2'd3 && b != 4'd0) return ITER;
    return 0;
  endfunction

  task automatic load_ops(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    state = S_LOAD_A; sw = a;
    tick();
    chk("loada_entry_clears_result", result, 8'h00);
    chk("loada_entry_clears_err", err, 1'b0);
    state = S_LOAD_B; sw = b;
    tick();
    state = S_LOAD_OP; sw = {2'b00, op};
    tick();
    chk("operand_a_latched", operand_a, a);
    chk("operand_b_latched", operand_b, b);
  endtask

  // Observed right after the exec_start edge; counts busy cycles until done.
  task automatic wait_done(output int busy_cycles, output bit got_done);
    busy_cycles = 0;
    got_done = 1'b0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      if (done) got_done = 1'b1;
      else begin
        if (busy) busy_cycles++;
        tick();
      end
    end
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                        input logic [7:0] exp_res, input logic exp_err, input int exp_busy);
    int  bc;
    bit  gd;
    load_ops(a, b, op);
    state = S_EXEC; sw = ~a;
    tick();
    wait_done(bc, gd);
    chk("done_seen", gd, 1'b1);
    chk("busy_cycles", bc, exp_busy);
    chk("result", result, exp_res);
    chk("err", err, exp_err);
    chk("busy_low_at_done", busy, 1'b0);
    tick();
    chk("done_single_cycle", done, 1'b0);
    chk("result_hold_exec", result, exp_res);
    state = S_SHOW;
    tick();
    chk("result_hold_show", result, exp_res);
    chk("operand_a_stable", operand_a, a);
    chk("done_quiet_show", done, 1'b0);
    state = 3'b111;
    tick();
    chk("result_hold_invalid", result, exp_res);
    chk("err_hold_invalid", err, exp_err);
    $display("op=%0d a=%0d b=%0d result=%02h err=%0b busy_cycles=%0d done=%0b",
             op, a, b, result, err, bc, gd);
    state = S_IDLE;
    tick();
  endtask

  initial begin
    int  bc;
    bit  gd;
    logic [3:0] ra, rb;
    logic [1:0] rop;

    vecs[0] = '{a: 4'd9,  b: 4'd8,  op: 2'd0, exp_res: 8'h11, exp_err: 1'b0, exp_busy: 0};
    vecs[1] = '{a: 4'd3,  b: 4'd5,  op: 2'd1, exp_res: 8'hFE, exp_err: 1'b0, exp_busy: 0};
    vecs[2] = '{a: 4'd15, b: 4'd15, op: 2'd2, exp_res: 8'hE1, exp_err: 1'b0, exp_busy: 4};
    vecs[3] = '{a: 4'd13, b: 4'd4,  op: 2'd3, exp_res: 8'h13, exp_err: 1'b0, exp_busy: 4};
    vecs[4] = '{a: 4'd13, b: 4'd0,  op: 2'd3, exp_res: 8'hFF, exp_err: 1'b1, exp_busy: 0};
    vecs[5] = '{a: 4'd15, b: 4'd15, op: 2'd0, exp_res: 8'h1E, exp_err: 1'b0, exp_busy: 0};
    vecs[6] = '{a: 4'd0,  b: 4'd15, op: 2'd1, exp_res: 8'hF1, exp_err: 1'b0, exp_busy: 0};

    #2 reset = 1'b0;
    #8;
    chk("reset_operand_a", operand_a, 4'd0);
    chk("reset_operand_b", operand_b, 4'd0);
    chk("reset_result", result, 8'd0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_err", err, 1'b0);
    #2 reset = 1'b1;

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp_res, vecs[i].exp_err, vecs[i].exp_busy);

    for (int i = 0; i < 25; i++) begin
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      rop = 2'($urandom_range(0, 3));
      run_op(ra, rb, rop, model_res(ra, rb, rop), (rop == 2'd3 && rb == 4'd0), model_busy(rb, rop));
    end

    // MUL aborted by IDLE after two busy cycles, then restarted.
    load_ops(4'd15, 4'd15, 2'd2);
    state = S_EXEC;
    tick();
    chk("abort_busy_1", busy, 1'b1);
    tick();
    chk("abort_busy_2", busy, 1'b1);
    state = S_IDLE;
    tick();
    chk("abort_busy_drop", busy, 1'b0);
    chk("abort_no_done", done, 1'b0);
    chk("abort_result_kept", result, 8'h00);
    tick();
    chk("abort_no_late_done", done, 1'b0);
    state = S_EXEC;
    tick();
    wait_done(bc, gd);
    chk("restart_done_seen", gd, 1'b1);
    chk("restart_busy_cycles", bc, ITER);
    chk("restart_result", result, 8'hE1);
    $display("abort/restart mul a=15 b=15 result=%02h busy_cycles=%0d", result, bc);
    state = S_IDLE;
    tick();

    // Asynchronous reset in the middle of a division.
    load_ops(4'd13, 4'd4, 2'd3);
    state = S_EXEC;
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    chk("async_rst_operand_a", operand_a, 4'd0);
    chk("async_rst_operand_b", operand_b, 4'd0);
    chk("async_rst_result", result, 8'd0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_done", done, 1'b0);
    chk("async_rst_err", err, 1'b0);
    state = S_IDLE;
    @(posedge clk);
    #2 reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_no_done", done, 1'b0);
      chk("post_rst_no_busy", busy, 1'b0);
    end
    // Previous state resets to IDLE, so EXEC now is a fresh ADD of 0+0.
    state = S_EXEC;
    tick();
    chk("post_rst_exec_done", done, 1'b1);
    chk("post_rst_exec_result", result, 8'h00);
    $display("async reset mid-div, then exec: result=%02h done=%0b", result, done);
    state = S_IDLE;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
